// File: rtl/keypad_pkg.sv
// Shared types, key map and row-decode helper for the 4x4 keypad scanner.
// Pure declarations: no latency, no flow control.
// Imported by keypad_scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } row_hit_t;

    // Indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Anything other than exactly one low bit (idle or ghosting) is not a hit.
    function automatic row_hit_t onehot_low_idx(input logic [3:0] v);
        row_hit_t h;
        h.vld = 1'b1;
        h.idx = 2'd0;
        case (v)
            4'b1110: h.idx = 2'd0;
            4'b1101: h.idx = 2'd1;
            4'b1011: h.idx = 2'd2;
            4'b0111: h.idx = 2'd3;
            default: h.vld = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles from d to q.
// No flow control; q resets to RST_VAL.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one pulse per press.
// Latency: 2-cycle row sync, accept DEBOUNCE_CYCLES after detection.
// No backpressure: key_valid is a single-cycle pulse, consumer must take it.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    scan_state_t   state, state_nxt;
    logic [1:0]    col_idx, col_idx_nxt, col_inc;
    logic [1:0]    row_idx, row_idx_nxt;
    logic [CW-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [CW-1:0] deb_cnt, deb_cnt_nxt;
    logic [3:0]    col_n_nxt, key_code_nxt;
    logic          key_valid_nxt, key_held_nxt;
    logic [3:0]    rows_s, latched_pat;
    logic          row_lvl;
    row_hit_t      hit;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (reset),
        .d   (row_n),
        .q   (rows_s)
    );

    assign hit         = onehot_low_idx(rows_s);
    assign col_inc     = col_idx + 2'd1;
    assign latched_pat = ~(4'b0001 << row_idx);
    assign row_lvl     = rows_s[row_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            col_n     <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_idx_nxt;
            row_idx   <= row_idx_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            deb_cnt   <= deb_cnt_nxt;
            col_n     <= col_n_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_idx_nxt   = col_idx;
        row_idx_nxt   = row_idx;
        dwell_cnt_nxt = dwell_cnt;
        deb_cnt_nxt   = deb_cnt;
        col_n_nxt     = col_n;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;

        case (state)
            SCAN: begin
                if (dwell_cnt == SCAN_LAST) begin
                    dwell_cnt_nxt = '0;
                    if (hit.vld) begin
                        row_idx_nxt = hit.idx;
                        deb_cnt_nxt = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_inc;
                        col_n_nxt   = ~(4'b0001 << col_inc);
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (rows_s == latched_pat) begin
                    if (deb_cnt == DEB_LAST) begin
                        key_code_nxt  = KEYMAP[row_idx][col_idx];
                        key_valid_nxt = 1'b1;
                        key_held_nxt  = 1'b1;
                        state_nxt     = HELD;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 1'b1;
                    end
                end else begin
                    // Bounce or a second key: abandon and move on to the next column.
                    state_nxt     = SCAN;
                    dwell_cnt_nxt = '0;
                    col_idx_nxt   = col_inc;
                    col_n_nxt     = ~(4'b0001 << col_inc);
                end
            end

            HELD: begin
                if (row_lvl) begin
                    deb_cnt_nxt = '0;
                    state_nxt   = RELEASE;
                end
            end

            RELEASE: begin
                if (!row_lvl) begin
                    state_nxt = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    key_held_nxt  = 1'b0;
                    state_nxt     = SCAN;
                    col_idx_nxt   = 2'd0;
                    col_n_nxt     = 4'b1110;
                    dwell_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end

            default: state_nxt = SCAN;
        endcase
    end

endmodule
